// File: rtl/palette_fade_ctrl.sv
// 16-entry RGB palette lookup with frame-paced brightness fade (levels 0..8).
// Optional palette write port enabled by defining PALETTE_WR_EN.
module palette_fade_ctrl #(
  parameter int unsigned FADE_FRAMES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        fade_start,
  input  logic        fade_dir,
  input  logic [3:0]  colorIdx,
`ifdef PALETTE_WR_EN
  input  logic        pal_we,
  input  logic [3:0]  pal_addr,
  input  logic [23:0] pal_wdata,
`endif
  output logic        fade_busy,
  output logic        fade_done,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LEVEL_FULL = 4'd8;
  localparam logic [3:0] LEVEL_ZERO = 4'd0;
  localparam logic [7:0] LAST_FRAME = 8'(FADE_FRAMES - 1);

  state_t      state_r;
  logic [3:0]  level_r;
  logic [3:0]  level_next_s;
  logic [7:0]  frame_cnt_r;
  logic        dir_r;
  logic [23:0] entry_s;

  function automatic logic [23:0] default_entry(input logic [3:0] idx);
    logic [23:0] e;
    case (idx)
      4'h0:    e = 24'h282246;
      4'h1:    e = 24'h213822;
      4'h2:    e = 24'h3E6B41;
      4'h3:    e = 24'h80BB84;
      4'h4:    e = 24'hD624C1;
      4'h5:    e = 24'h252525;
      4'h6:    e = 24'h000000;
      4'h7:    e = 24'h9A9A9A;
      4'h8:    e = 24'hFF9F33;
      4'h9:    e = 24'hFFFFFF;
      4'hA:    e = 24'h525468;
      4'hB:    e = 24'h8780A8;
      default: e = 24'h282246;
    endcase
    return e;
  endfunction

  // Product is at most 255*8 so 12 bits never overflow; >>3 truncates.
  function automatic logic [7:0] scale_chan(input logic [7:0] chan, input logic [3:0] lvl);
    logic [11:0] prod;
    prod = {4'd0, chan} * {8'd0, lvl};
    return 8'(prod >> 3);
  endfunction

  function automatic logic [3:0] target_level(input logic dir);
    return dir ? LEVEL_FULL : LEVEL_ZERO;
  endfunction

  function automatic logic [3:0] step_level(input logic [3:0] lvl, input logic up);
    logic [3:0] nxt;
    if (up) begin
      nxt = (lvl >= LEVEL_FULL) ? LEVEL_FULL : lvl + 4'd1;
    end else begin
      nxt = (lvl == LEVEL_ZERO) ? LEVEL_ZERO : lvl - 4'd1;
    end
    return nxt;
  endfunction

`ifdef PALETTE_WR_EN
  logic [23:0] pal_r [16];

  // Palette storage: reset reloads the default colours, writes accepted in any state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) begin
        pal_r[i] <= default_entry(4'(i));
      end
    end else if (pal_we) begin
      pal_r[pal_addr] <= pal_wdata;
    end
  end

  // Read sees the pre-write contents, so a same-cycle write shows up one cycle later.
  always_comb begin
    entry_s = pal_r[colorIdx];
  end
`else
  // Constant palette lookup.
  always_comb begin
    entry_s = default_entry(colorIdx);
  end
`endif

  // Saturating next brightness for a STEP cycle.
  always_comb begin
    level_next_s = step_level(level_r, dir_r);
  end

  // Registered pixel output scaled by the current brightness level.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      VGA_R <= 8'd0;
      VGA_G <= 8'd0;
      VGA_B <= 8'd0;
    end else begin
      VGA_R <= scale_chan(entry_s[23:16], level_r);
      VGA_G <= scale_chan(entry_s[15:8],  level_r);
      VGA_B <= scale_chan(entry_s[7:0],   level_r);
    end
  end

  // Fade sequencer; busy/done are registered alongside the state they describe.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= S_IDLE;
      level_r     <= LEVEL_FULL;
      frame_cnt_r <= 8'd0;
      dir_r       <= 1'b0;
      fade_busy   <= 1'b0;
      fade_done   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          fade_busy <= 1'b0;
          fade_done <= 1'b0;
          if (fade_start) begin
            dir_r       <= fade_dir;
            frame_cnt_r <= 8'd0;
            if (level_r == target_level(fade_dir)) begin
              state_r   <= S_DONE;
              fade_done <= 1'b1;
            end else begin
              state_r   <= S_WAIT;
              fade_busy <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          fade_busy <= 1'b1;
          fade_done <= 1'b0;
          if (frame_start) begin
            if (frame_cnt_r == LAST_FRAME) begin
              frame_cnt_r <= 8'd0;
              state_r     <= S_STEP;
            end else begin
              frame_cnt_r <= frame_cnt_r + 8'd1;
            end
          end
        end
        S_STEP: begin
          level_r <= level_next_s;
          if (level_next_s == target_level(dir_r)) begin
            state_r   <= S_DONE;
            fade_busy <= 1'b0;
            fade_done <= 1'b1;
          end else begin
            state_r   <= S_WAIT;
            fade_busy <= 1'b1;
            fade_done <= 1'b0;
          end
        end
        S_DONE: begin
          state_r   <= S_IDLE;
          fade_busy <= 1'b0;
          fade_done <= 1'b0;
        end
        default: begin
          state_r   <= S_IDLE;
          fade_busy <= 1'b0;
          fade_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Scoreboard bench for palette_fade_ctrl: stimulus queues expected pixels, a monitor thread checks them.
module tb_palette_fade_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_start;
  logic       fade_start;
  logic       fade_dir;
  logic [3:0] colorIdx;
  logic       fade_busy;
  logic       fade_done;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
`ifdef PALETTE_WR_EN
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [23:0] pal_wdata;
`endif

  int checks = 0;
  int failures = 0;
  int done_total = 0;
  int busy_total = 0;
  logic vld = 1'b0;
  logic [23:0] exp_q[$];
  string nm_q[$];

  palette_fade_ctrl #(.FADE_FRAMES(4)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_start(frame_start),
    .fade_start(fade_start),
    .fade_dir(fade_dir),
    .colorIdx(colorIdx),
`ifdef PALETTE_WR_EN
    .pal_we(pal_we),
    .pal_addr(pal_addr),
    .pal_wdata(pal_wdata),
`endif
    .fade_busy(fade_busy),
    .fade_done(fade_done),
    .VGA_R(VGA_R),
    .VGA_G(VGA_G),
    .VGA_B(VGA_B)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic px(input logic [3:0] idx, input logic [23:0] e, input string n);
    @(negedge Clk);
    colorIdx = idx;
    exp_q.push_back(e);
    nm_q.push_back(n);
    vld = 1'b1;
    @(negedge Clk);
    vld = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk) frame_start = 1'b1;
      @(negedge Clk) frame_start = 1'b0;
      @(negedge Clk);
    end
  endtask

  task automatic start(input logic d);
    @(negedge Clk);
    fade_start = 1'b1;
    fade_dir = d;
    @(negedge Clk);
    fade_start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge Clk);
  endtask

  task automatic wait_done(input int base, input string n);
    int k;
    k = 0;
    while (done_total == base && k < 40) begin
      @(negedge Clk);
      k++;
    end
    settle();
    chk(n, done_total - base, 1);
  endtask

  initial begin
    int bd;
    int bb;
    Reset = 1'b1;
    frame_start = 1'b0;
    fade_start = 1'b0;
    fade_dir = 1'b0;
    colorIdx = 4'd0;
`ifdef PALETTE_WR_EN
    pal_we = 1'b0;
    pal_addr = 4'd0;
    pal_wdata = 24'd0;
`endif

    // Monitor: pops one expected pixel per flagged cycle and tallies done/busy cycles.
    fork
      begin
        logic v;
        logic [23:0] e;
        string n;
        forever begin
          @(posedge Clk);
          v = vld;
          @(negedge Clk);
          if (v) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL sb_underflow: got empty queue expected an entry");
            end else begin
              e = exp_q.pop_front();
              n = nm_q.pop_front();
              chk(n, {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, e});
            end
          end
          if (fade_done === 1'b1) done_total++;
          if (fade_busy === 1'b1) busy_total++;
        end
      end
    join_none

    repeat (3) @(negedge Clk);
    chk("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    chk("rst_busy", {31'd0, fade_busy}, 32'd0);
    chk("rst_done", {31'd0, fade_done}, 32'd0);
    Reset = 1'b0;

    px(4'h3, 24'h80BB84, "full_idx3");
    px(4'hF, 24'h282246, "full_idxF");
    px(4'h9, 24'hFFFFFF, "full_idx9");
    px(4'h4, 24'hD624C1, "full_idx4");
    px(4'hA, 24'h525468, "full_idxA");

    bd = done_total; bb = busy_total;
    start(1'b1);
    settle();
    chk("in_at_full_done", done_total - bd, 1);
    chk("in_at_full_busy", busy_total - bb, 0);

    bd = done_total;
    start(1'b0);
    chk("out_busy", {31'd0, fade_busy}, 32'd1);
    frames(16);
    px(4'h3, 24'h405D42, "lvl4_idx3");
    px(4'h9, 24'h7F7F7F, "lvl4_idx9");
    px(4'h4, 24'h6B1260, "lvl4_idx4");
    chk("out_half_nodone", done_total - bd, 0);
    chk("out_half_busy", {31'd0, fade_busy}, 32'd1);
    frames(16);
    wait_done(bd, "out_done_once");
    chk("out_end_busy", {31'd0, fade_busy}, 32'd0);
    px(4'h9, 24'h000000, "lvl0_idx9");
    px(4'h3, 24'h000000, "lvl0_idx3");
    px(4'h8, 24'h000000, "lvl0_idx8");
    frames(4);
    px(4'h9, 24'h000000, "hold_black");

    bd = done_total; bb = busy_total;
    start(1'b0);
    settle();
    chk("out_at_zero_done", done_total - bd, 1);
    chk("out_at_zero_busy", busy_total - bb, 0);

    bd = done_total;
    start(1'b1);
    frames(4);
    px(4'h9, 24'h1F1F1F, "lvl1_idx9");
    px(4'h8, 24'h1F1306, "lvl1_idx8");
    frames(28);
    wait_done(bd, "in_done_once");
    px(4'h3, 24'h80BB84, "in_full_idx3");

    bd = done_total;
    start(1'b0);
    frames(12);
    px(4'h3, 24'h507452, "lvl5_idx3");
    start(1'b1);
    chk("ignore_busy", {31'd0, fade_busy}, 32'd1);
    frames(4);
    px(4'h3, 24'h405D42, "ignored_start");
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    settle();
    chk("abort_nodone", done_total - bd, 0);
    chk("abort_busy", {31'd0, fade_busy}, 32'd0);
    px(4'h3, 24'h80BB84, "abort_lvl8");
    bd = done_total; bb = busy_total;
    start(1'b1);
    settle();
    chk("abort_idle_done", done_total - bd, 1);
    chk("abort_idle_busy", busy_total - bb, 0);

`ifdef PALETTE_WR_EN
    @(negedge Clk);
    pal_we = 1'b1;
    pal_addr = 4'd3;
    pal_wdata = 24'h102030;
    colorIdx = 4'd3;
    exp_q.push_back(24'h80BB84);
    nm_q.push_back("wr_old");
    vld = 1'b1;
    @(negedge Clk);
    pal_we = 1'b0;
    exp_q.push_back(24'h102030);
    nm_q.push_back("wr_new");
    @(negedge Clk);
    vld = 1'b0;
    px(4'h3, 24'h102030, "wr_hold");
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    px(4'h3, 24'h80BB84, "wr_reset_restore");
`endif

    settle();
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
